fle_ccff_loader: RTL and testbench

- Configuration-chain programming controller for the logic-element tiles.
- Accepts the configuration bitstream as words over a valid/ready stream from the host or bitstream buffer.
- Serialises the words onto the tile chain input ccff_head and generates prog_clk as a strobe at clk/2.
- Optional verify pass: reshifts the same bitstream and compares ccff_tail bit-by-bit against the expected stream, counting mismatches.

---
 rtl/fle_ccff_loader.sv | 187 ++++++++++++++++++
 tb/tb_fle_ccff_loader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fle_ccff_loader.sv
// ---------------------------------------------------------------------------
// fle_ccff_loader
//   Programs the configuration flip-flop chain of the logic-element tiles.
//   Bitstream words arrive over a valid/ready stream. Each word is shifted
//   out LSB first on ccff_head, and every bit gets one prog_clk strobe at
//   clk/2. A verify pass reshifts a stream and compares ccff_tail with the
//   expected bits. It counts the mismatches in a saturating counter.
//
// Ports
//   clk          in   system clock, rising edge
//   pReset       in   synchronous active-high reset; aborts a pass at once
//   start        in   one-cycle pulse that starts a pass (ignored while busy)
//   verify       in   sampled with start: 0 = load pass, 1 = verify pass
//   cfg_data     in   bitstream word, bit 0 shifted first
//   cfg_valid    in   cfg_data is valid
//   cfg_ready    out  a word is accepted this cycle (FETCH state)
//   prog_clk     out  chain shift clock, registered
//   ccff_head    out  serial data into the chain, registered
//   ccff_tail    in   serial data out of the chain
//   busy         out  a pass is in progress
//   done         out  the last pass completed; held until the next start
//   mismatch_cnt out  verify mismatches, saturating at all-ones
// ---------------------------------------------------------------------------
module fle_ccff_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              pReset,
  input  logic              start,
  input  logic              verify,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              prog_clk,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  // The bit counter only has to reach CHAIN_LEN-1. It is sized from the
  // chain length, so a narrow mismatch counter cannot truncate a pass.
  localparam int BIT_W = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam int BIW_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(CHAIN_LEN - 1);
  localparam logic [BIW_W-1:0] LAST_BIW = BIW_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_verify;
  logic              w_verify_nxt;
  logic [WORD_W-1:0] r_shreg;
  logic [WORD_W-1:0] w_shreg_nxt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [BIT_W-1:0]  w_bit_cnt_nxt;
  logic [BIW_W-1:0]  r_bit_in_word;
  logic [BIW_W-1:0]  w_bit_in_word_nxt;
  logic [CNT_W-1:0]  r_mm_cnt;
  logic [CNT_W-1:0]  w_mm_cnt_nxt;
  logic              r_prog_clk;
  logic              r_ccff_head;
  logic              w_ccff_head_nxt;
  logic              r_busy;
  logic              r_done;
  logic              w_busy_nxt;

  // Next-state and datapath update for the shift controller.
  always_comb begin
    w_state_nxt       = r_state;
    w_verify_nxt      = r_verify;
    w_shreg_nxt       = r_shreg;
    w_bit_cnt_nxt     = r_bit_cnt;
    w_bit_in_word_nxt = r_bit_in_word;
    w_mm_cnt_nxt      = r_mm_cnt;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_verify_nxt  = verify;
          w_bit_cnt_nxt = {BIT_W{1'b0}};
          w_mm_cnt_nxt  = {CNT_W{1'b0}};
          w_state_nxt   = S_FETCH;
        end else begin
          w_state_nxt   = r_state;
        end
      end
      S_FETCH: begin
        if (cfg_valid) begin
          w_shreg_nxt       = cfg_data;
          w_bit_in_word_nxt = {BIW_W{1'b0}};
          w_state_nxt       = S_SHIFT_LO;
        end else begin
          w_state_nxt       = S_FETCH;
        end
      end
      S_SHIFT_LO: begin
        // Before shift k the tail presents bit k of the previously shifted
        // stream. Compare it with the bit that is about to be written.
        if (r_verify && (ccff_tail != r_shreg[0]) && (r_mm_cnt != CNT_MAX)) begin
          w_mm_cnt_nxt = r_mm_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          w_mm_cnt_nxt = r_mm_cnt;
        end
        w_state_nxt = S_SHIFT_HI;
      end
      S_SHIFT_HI: begin
        if (r_bit_cnt == LAST_BIT) begin
          // Any unshifted bits of the current word are dropped.
          w_state_nxt = S_DONE;
        end else begin
          w_bit_cnt_nxt = r_bit_cnt + {{(BIT_W-1){1'b0}}, 1'b1};
          if (r_bit_in_word == LAST_BIW) begin
            w_state_nxt = S_FETCH;
          end else begin
            w_shreg_nxt       = r_shreg >> 1;
            w_bit_in_word_nxt = r_bit_in_word + {{(BIW_W-1){1'b0}}, 1'b1};
            w_state_nxt       = S_SHIFT_LO;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output pre-decode from the next state, so that every output is a flop.
  always_comb begin
    w_busy_nxt = (w_state_nxt == S_FETCH) || (w_state_nxt == S_SHIFT_LO) ||
                 (w_state_nxt == S_SHIFT_HI);
    // Head changes only when a bit is presented. It then stays stable
    // through the following SHIFT_HI cycle.
    if (w_state_nxt == S_SHIFT_LO) begin
      w_ccff_head_nxt = w_shreg_nxt[0];
    end else begin
      w_ccff_head_nxt = r_ccff_head;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (pReset) begin
      r_state       <= S_IDLE;
      r_verify      <= 1'b0;
      r_shreg       <= {WORD_W{1'b0}};
      r_bit_cnt     <= {BIT_W{1'b0}};
      r_bit_in_word <= {BIW_W{1'b0}};
      r_mm_cnt      <= {CNT_W{1'b0}};
      r_prog_clk    <= 1'b0;
      r_ccff_head   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_verify      <= w_verify_nxt;
      r_shreg       <= w_shreg_nxt;
      r_bit_cnt     <= w_bit_cnt_nxt;
      r_bit_in_word <= w_bit_in_word_nxt;
      r_mm_cnt      <= w_mm_cnt_nxt;
      r_prog_clk    <= (w_state_nxt == S_SHIFT_HI);
      r_ccff_head   <= w_ccff_head_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= (w_state_nxt == S_DONE);
    end
  end

  assign cfg_ready    = (r_state == S_FETCH);
  assign prog_clk     = r_prog_clk;
  assign ccff_head    = r_ccff_head;
  assign busy         = r_busy;
  assign done         = r_done;
  assign mismatch_cnt = r_mm_cnt;

endmodule

// File: tb/tb_fle_ccff_loader.sv
// ---------------------------------------------------------------------------
// tb_fle_ccff_loader
//   Drives two loaders from the same stimulus. Instance a uses the default
//   16-bit counter and instance b uses a 2-bit counter. Each instance shifts
//   into its own model of a 20-bit tile chain. The expected chain contents,
//   handshake counts, edge counts, pass lengths and mismatch counts all
//   come from the bitstream words themselves.
// ---------------------------------------------------------------------------
module tb_fle_ccff_loader;

  localparam int CL = 20;
  localparam int WW = 8;
  localparam int NW = (CL + WW - 1) / WW;

  logic          clk = 1'b0;
  logic          pReset;
  logic          start;
  logic          verify;
  logic [WW-1:0] cfg_data;
  logic          cfg_valid;

  logic          cfg_ready_a, prog_clk_a, head_a, tail_a, busy_a, done_a;
  logic [15:0]   mm_a;
  logic          cfg_ready_b, prog_clk_b, head_b, tail_b, busy_b, done_b;
  logic [1:0]    mm_b;

  logic [CL-1:0] chain_a;
  logic [CL-1:0] chain_b;
  int            edges_a = 0;
  int            edges_b = 0;

  int            checks = 0;
  int            errors = 0;

  logic [WW-1:0] words  [NW];
  int            stalls [NW];
  logic [CL-1:0] prev_bits;
  bit            prev_valid = 1'b0;

  fle_ccff_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CNT_W(16)) dut_a (
    .clk(clk), .pReset(pReset), .start(start), .verify(verify),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a),
    .prog_clk(prog_clk_a), .ccff_head(head_a), .ccff_tail(tail_a),
    .busy(busy_a), .done(done_a), .mismatch_cnt(mm_a)
  );

  fle_ccff_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CNT_W(2)) dut_b (
    .clk(clk), .pReset(pReset), .start(start), .verify(verify),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b),
    .prog_clk(prog_clk_b), .ccff_head(head_b), .ccff_tail(tail_b),
    .busy(busy_b), .done(done_b), .mismatch_cnt(mm_b)
  );

  always #5 clk = ~clk;

  // Tile chain models: the first bit shifted in ends up at the tail.
  always @(posedge prog_clk_a) begin
    chain_a <= {chain_a[CL-2:0], head_a};
    edges_a <= edges_a + 1;
  end
  always @(posedge prog_clk_b) begin
    chain_b <= {chain_b[CL-2:0], head_b};
    edges_b <= edges_b + 1;
  end
  assign tail_a = chain_a[CL-1];
  assign tail_b = chain_b[CL-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one pass. The words and stalls come from the module-level arrays.
  // mid_start: loop cycle in which start is pulsed again while busy (-1 = none).
  // abort_edge: pReset is applied once this many edges occur (0 = none).
  task automatic run_pass(input bit v, input int mid_start, input int abort_edge);
    int            e0a, e0b, hs, widx, stall_left, busy_cyc, nmm, total_stall;
    bit            fin;
    logic [CL-1:0] nb;
    logic [CL-1:0] exp_chain;
    logic [WW-1:0] wt;

    // Reference: the stream bits, the expected chain image and the mismatches.
    total_stall = 0;
    for (int i = 0; i < NW; i++) total_stall += stalls[i];
    nmm = 0;
    for (int k = 0; k < CL; k++) begin
      wt = words[k / WW];
      nb[k] = wt[k % WW];
      exp_chain[CL-1-k] = nb[k];
      if (prev_valid && (nb[k] != prev_bits[k])) nmm++;
    end
    if (!v) nmm = 0;

    e0a = edges_a;
    e0b = edges_b;
    @(negedge clk);
    start = 1'b1; verify = v; cfg_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; verify = 1'($urandom_range(0, 1));
    check("start_busy", {31'd0, busy_a}, 32'd1);
    check("start_done_clr", {31'd0, done_a}, 32'd0);
    check("start_mm_clr", {16'd0, mm_a}, 32'd0);

    widx = 0; stall_left = stalls[0]; hs = 0; busy_cyc = 0; fin = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (done_a) begin
        fin = 1'b1;
      end else begin
        busy_cyc++;
        start = (cyc == mid_start);
        if (start) verify = ~v;
        if (abort_edge > 0 && (edges_a - e0a) == abort_edge) begin
          pReset = 1'b1; start = 1'b0; cfg_valid = 1'b0;
          @(negedge clk);
          check("abort_busy", {31'd0, busy_a}, 32'd0);
          check("abort_prog_clk", {31'd0, prog_clk_a}, 32'd0);
          check("abort_ready", {31'd0, cfg_ready_a}, 32'd0);
          check("abort_done", {31'd0, done_a}, 32'd0);
          pReset = 1'b0;
          repeat (4) @(negedge clk);
          check("abort_edges", edges_a - e0a, abort_edge);
          check("abort_idle", {31'd0, busy_a}, 32'd0);
          prev_valid = 1'b0;
          return;
        end
        if (cfg_ready_a && stall_left > 0) begin
          cfg_valid = 1'b0;
          stall_left--;
          check("stall_prog_clk", {31'd0, prog_clk_a}, 32'd0);
          check("stall_ready", {31'd0, cfg_ready_b}, 32'd1);
        end else if (cfg_ready_a && widx < NW) begin
          cfg_valid = 1'b1;
          cfg_data  = words[widx];
          widx++;
          stall_left = (widx < NW) ? stalls[widx] : 0;
        end else begin
          // Junk while not ready; the loader must not take it.
          cfg_valid = 1'($urandom_range(0, 1));
          cfg_data  = WW'($urandom);
        end
        if (cfg_valid && cfg_ready_a) hs++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    cfg_valid = 1'b0;

    check("pass_finished", {31'd0, fin}, 32'd1);
    check("edges_a", edges_a - e0a, CL);
    check("edges_b", edges_b - e0b, CL);
    check("handshakes", hs, NW);
    check("pass_cycles", busy_cyc, 2 * CL + NW + total_stall);
    check("done_busy", {31'd0, busy_a}, 32'd0);
    check("done_ready", {31'd0, cfg_ready_a}, 32'd0);
    check("done_prog_clk", {31'd0, prog_clk_a}, 32'd0);
    check("chain_a", {12'd0, chain_a}, {12'd0, exp_chain});
    check("chain_b", {12'd0, chain_b}, {12'd0, exp_chain});
    check("mm_a", {16'd0, mm_a}, nmm);
    check("mm_b", {30'd0, mm_b}, (nmm > 3) ? 3 : nmm);
    repeat (3) @(negedge clk);
    check("done_sticky", {31'd0, done_b}, 32'd1);
    check("mm_hold", {16'd0, mm_a}, nmm);

    prev_bits  = nb;
    prev_valid = 1'b1;
  endtask

  task automatic set_words(input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                           input logic [WW-1:0] w2);
    words[0] = w0; words[1] = w1; words[2] = w2;
    for (int i = 0; i < NW; i++) stalls[i] = 0;
  endtask

  initial begin
    pReset = 1'b1; start = 1'b0; verify = 1'b0;
    cfg_data = '0; cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, cfg_ready_a}, 32'd0);
    check("rst_prog_clk", {31'd0, prog_clk_a}, 32'd0);
    check("rst_head", {31'd0, head_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_mm", {16'd0, mm_a}, 32'd0);
    pReset = 1'b0;
    @(negedge clk);
    check("idle_no_busy", {31'd0, busy_b}, 32'd0);

    // Directed load and pass timing.
    set_words(8'hA5, 8'h3C, 8'h0F);
    run_pass(1'b0, -1, 0);
    // Explicit chain image: 0x0F[3:0], then 0x3C, then 0xA5 toward the tail.
    check("chain_const", {12'd0, chain_a}, {12'd0, 20'b1010_0101_0011_1100_1111});

    run_pass(1'b1, -1, 0);                       // identical verify
    set_words(8'h85, 8'h3C, 8'h0F);
    run_pass(1'b1, -1, 0);                       // one flipped bit

    set_words(8'hA5, 8'h3C, 8'h0F);
    stalls[1] = 10;
    run_pass(1'b0, -1, 0);                       // backpressure

    set_words(WW'($urandom), WW'($urandom), WW'($urandom));
    run_pass(1'b0, -1, 7);                       // abort mid-pass
    set_words(8'hA5, 8'h3C, 8'h0F);
    run_pass(1'b0, -1, 0);                       // fresh load after abort

    run_pass(1'b0, 12, 0);                       // start while busy

    set_words(~8'hA5, ~8'h3C, ~8'h0F);
    run_pass(1'b1, -1, 0);                       // saturation on instance b

    // Randomized passes against the reference.
    for (int p = 0; p < 8; p++) begin
      set_words(WW'($urandom), WW'($urandom), WW'($urandom));
      for (int i = 0; i < NW; i++) stalls[i] = $urandom_range(0, 3);
      run_pass(1'($urandom_range(0, 1)), ($urandom_range(0, 1) == 1) ? 20 : -1, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
